fc_stream_tx: RTL
=================

# fc_stream_tx

Serializing transmitter for the fully-connected pipeline. It captures the packed parallel result vector of one FC layer, here the 120 x 16-bit outputs produced on a `save` pulse. It then streams the words one per cycle as sign-extended 18-bit operands with an `ena` strobe and a matching weight-row address, which is the serial input the next FC layer's PE array consumes. It owns the handshake between layers: load, stall, per-word strobe, last marker, done pulse and overrun flag.

## Interface
- N, 120, number of words in the packed vector
- DW, 16, input word width (signed)
- OW, 18, output operand width (signed, OW >= DW)
- AW, 7, address width; must satisfy 2^AW >= N
- clk  in  1  clock, rising-edge
- reset  in  1  reset, asynchronous, active-high
- load  in  1  capture request; accepted only when busy=0
- din_vec  in  N*DW  packed vector; word k = din_vec[N*DW-1-k*DW -: DW] (word 0 at MSBs)
- relu_en  in  1  clamp negative words to 0; sampled with load
- stall  in  1  downstream hold; freezes streaming while high
- dout  out  OW  current word, signed, sign-extended (or ReLU'd)
- ena  out  1  dout valid this cycle; consumer accumulates on every ena=1 cycle
- waddr  out  AW  index of the current word (weight-ROM row)
- last  out  1  high with word N-1
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the final word is consumed
- err  out  1  sticky overrun flag: load seen while busy

## Operation
- States: IDLE, STREAM. `busy` = (state==STREAM).
- IDLE, load=1 at edge: capture din_vec and relu_en into internal registers. Set idx=0, go to STREAM. Clear err.
- STREAM, at each edge with stall=0: if idx==N-1, go to IDLE and set done=1 for that one cycle. Otherwise idx <= idx+1.
- STREAM, edge with stall=1: hold idx, dout, waddr and last.
- ena = busy & ~stall. This is combinational from stall so the consumer never double-counts a held word.
- dout = sext(word[idx]) to OW bits. If the captured relu_en=1 and word[idx] is negative, dout = 0.
- waddr = idx. last = busy & (idx==N-1).
- load=1 at an edge while busy=1: the load is ignored, captured data is unchanged, err <= 1. err clears only on reset or on the next accepted load.
- load in the done cycle: state is already IDLE, so the load is accepted. This gives back-to-back frames.
- Outputs are zero whenever not busy: dout=0, waddr=0, last=0.
- Reset value of every output: dout=0, ena=0, waddr=0, last=0, busy=0, done=0, err=0. Internal idx=0, state IDLE.

## Timing
- Latency: word 0 is on dout with ena=1 in the cycle immediately after the load edge.
- With no stall, ena is high for exactly N consecutive cycles (waddr 0..N-1).
- done goes high in the cycle after the last ena cycle and lasts exactly one cycle.
- Each stall cycle lengthens the frame by one cycle. The total count of ena=1 cycles is always N.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous). The frame is abandoned and done never pulses for it.
- Simultaneous load and last-word edge: load is ignored (busy=1) and err sets. Load is accepted only from the done cycle onward.
- stall while IDLE has no effect. stall on the last word delays done until the first edge with stall=0.

## Test plan
- Ramp load, word k = k-60, relu_en=0, stall=0 -> 120 ena cycles with waddr 0..119. dout = sext(k-60), e.g. word 0 = 18'h3FFC4. last only at waddr=119. done is a 1-cycle pulse the next cycle. busy falls with done.
- All words 16'hFFFF: relu_en=0 -> dout=18'h3FFFF for 120 cycles. Repeat with relu_en=1 -> dout=0 throughout, still 120 ena cycles.
- stall=1 for 3 cycles while waddr=50 -> ena=0 for those 3 cycles, dout/waddr hold word 50. Frame spans 123 cycles, ena count is 120.
- load pulse at waddr=30 with a different vector -> the stream continues with the original data and err=1 until the next accepted load clears it.
- reset pulse at waddr=60 -> all outputs 0 asynchronously and no done. A subsequent load restarts at waddr=0 with the new data.
- load asserted in the done cycle with a second vector -> the second frame's word 0 appears on the next cycle. There is exactly one ena-low cycle between frames and err stays 0.

Source files
------------

// File: rtl/fc_stream_tx.sv
// fc_stream_tx - serializing transmitter between FC layers.
//
// Captures a packed vector of N signed DW-bit words on an accepted load. It then
// streams the words one per cycle as sign-extended OW-bit operands, with an ena
// strobe and the matching weight-row address. An optional ReLU clamp is applied
// on the way out.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   load            capture request, accepted only while idle
//   din_vec         packed vector, word 0 in the MSBs
//   relu_en         clamp negative words to 0 (sampled with load)
//   stall           downstream hold; freezes the stream while high
//   dout            current operand (0 when idle)
//   ena             dout valid this cycle (busy & ~stall)
//   waddr           index of the current word (0 when idle)
//   last            high while word N-1 is presented
//   busy            frame in progress
//   done            one-cycle pulse after the final word is consumed
//   err             sticky overrun: load seen while busy
module fc_stream_tx #(
  parameter int N  = 120,
  parameter int DW = 16,
  parameter int OW = 18,
  parameter int AW = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [N*DW-1:0]      din_vec,
  input  logic                 relu_en,
  input  logic                 stall,
  output logic signed [OW-1:0] dout,
  output logic                 ena,
  output logic [AW-1:0]        waddr,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       idx, idx_nxt;
  logic                done_nxt, err_nxt, cap, at_end;
  logic                relu_q;
  logic [DW-1:0]       word_q [N];
  logic signed [DW-1:0] cur;

  assign at_end = (idx == AW'(N-1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    err_nxt   = err;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          cap       = 1'b1;
          state_nxt = STREAM;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      STREAM: begin
        // A load during a frame is dropped, even on the last-word edge.
        if (load) err_nxt = 1'b1;
        if (!stall) begin
          if (at_end) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // The payload needs no reset: it is only observed while busy, and busy
  // implies that a capture has already happened.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < N; k++)
        word_q[k] <= din_vec[N*DW-1-k*DW -: DW];
      relu_q <= relu_en;
    end
  end

  assign busy = (state == STREAM);
  assign cur  = word_q[idx];

  always_comb begin
    dout = '0;
    if (busy && !(relu_q && cur[DW-1]))
      dout = OW'(cur);
  end

  // ena follows stall combinationally, so a held word is never counted twice.
  assign ena   = busy & ~stall;
  assign waddr = busy ? idx : '0;
  assign last  = busy & at_end;

endmodule
